// File: rtl/keypad_scanner.sv
// 3x4 matrix keypad scanner: column drive, synchronized row sampling, per-frame
// key classification and a press/release debounce FSM with a one-cycle press pulse.
module keypad_scanner #(
    parameter int SCAN_DIV     = 4,
    parameter int DEBOUNCE_CNT = 3
) (
    input  logic       clk_2,
    input  logic       rst,
    input  logic [3:0] KEY_ROW,
    output logic [2:0] KEY_COL,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic       key_held
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONFIRM = 2'd1,
        HELD    = 2'd2,
        RELEASE = 2'd3
    } state_e;

    localparam logic [7:0] DWELL_MAX = 8'(SCAN_DIV - 1);
    localparam logic [3:0] DEB_LIMIT = 4'(DEBOUNCE_CNT);

    logic [3:0] row_meta_q, row_meta_d;
    logic [3:0] row_sync_q, row_sync_d;
    logic [1:0] col_q, col_d;
    logic [7:0] dwell_q, dwell_d;
    logic [1:0] hit_cnt_q, hit_cnt_d;   // 0 = none, 1 = single, 2 = multi (saturates)
    logic [3:0] hit_code_q, hit_code_d;
    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] cand_q, cand_d;
    logic [3:0] key_code_q, key_code_d;
    logic       key_valid_q, key_valid_d;

    logic       dwell_last;
    logic       frame_end;
    logic [2:0] col_ones;
    logic [1:0] row_idx;
    logic [3:0] col_code;
    logic [1:0] tot_cnt;
    logic [3:0] tot_code;
    logic       frame_single;
    logic [3:0] cnt_next;

    // Scan timing, row sampling and frame accumulation.
    // NOTE: every signal written in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        row_meta_d = KEY_ROW;
        row_sync_d = row_meta_q;

        dwell_last = (dwell_q == DWELL_MAX);
        frame_end  = dwell_last && (col_q == 2'd2);

        dwell_d = dwell_q + 8'd1;
        col_d   = col_q;
        if (dwell_last) begin
            dwell_d = '0;
            col_d   = (col_q == 2'd2) ? 2'd0 : col_q + 2'd1;
        end

        col_ones = 3'($countones(row_sync_q));
        row_idx  = '0;
        for (int r = 0; r < 4; r++) begin
            if (row_sync_q[r]) row_idx = 2'(r);
        end
        col_code = {2'b00, row_idx} * 4'd3 + {2'b00, col_q};

        tot_cnt  = hit_cnt_q;
        tot_code = hit_code_q;
        if (dwell_last) begin
            if (col_ones == 3'd1 && hit_cnt_q == 2'd0) begin
                tot_cnt  = 2'd1;
                tot_code = col_code;
            end else if (col_ones != 3'd0) begin
                tot_cnt = 2'd2;
            end
        end

        frame_single = frame_end && (tot_cnt == 2'd1);
        hit_cnt_d    = frame_end ? 2'd0 : tot_cnt;
        hit_code_d   = tot_code;
    end

    // Debounce FSM; it only moves on frame-end cycles and treats MULTI as NONE.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cand_d      = cand_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        cnt_next    = '0;

        if (frame_end) begin
            case (state_q)
                IDLE, CONFIRM: begin
                    if (!frame_single) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_next = (state_q == CONFIRM && tot_code == cand_q) ? cnt_q + 4'd1 : 4'd1;
                        cand_d   = tot_code;
                        if (cnt_next == DEB_LIMIT) begin
                            key_code_d  = tot_code;
                            key_valid_d = 1'b1;
                            state_d     = HELD;
                            cnt_d       = '0;
                        end else begin
                            state_d = CONFIRM;
                            cnt_d   = cnt_next;
                        end
                    end
                end
                HELD, RELEASE: begin
                    if (frame_single && tot_code == key_code_q) begin
                        state_d = HELD;
                        cnt_d   = '0;
                    end else begin
                        cnt_next = (state_q == RELEASE) ? cnt_q + 4'd1 : 4'd1;
                        if (cnt_next == DEB_LIMIT) begin
                            state_d = IDLE;
                            cnt_d   = '0;
                        end else begin
                            state_d = RELEASE;
                            cnt_d   = cnt_next;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_2) begin
        if (rst) begin
            row_meta_q  <= '0;
            row_sync_q  <= '0;
            col_q       <= '0;
            dwell_q     <= '0;
            hit_cnt_q   <= '0;
            hit_code_q  <= '0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            cand_q      <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
        end else begin
            row_meta_q  <= row_meta_d;
            row_sync_q  <= row_sync_d;
            col_q       <= col_d;
            dwell_q     <= dwell_d;
            hit_cnt_q   <= hit_cnt_d;
            hit_code_q  <= hit_code_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cand_q      <= cand_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
        end
    end

    assign KEY_COL   = 3'b001 << col_q;
    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;
    assign key_held  = (state_q == HELD) || (state_q == RELEASE);

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a keypad matrix model drives the rows and a
// frame-level run-length reference model predicts pulses, held state and key code.
module tb_keypad_scanner;

    localparam int S     = 4;
    localparam int D     = 3;
    localparam int FRAME = 3 * S;

    logic       clk_2 = 1'b0;
    logic       rst   = 1'b1;
    logic [3:0] KEY_ROW;
    logic [2:0] KEY_COL;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_held;

    logic [11:0] pressed = '0;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;          // rising edges since reset was released
    int pulses_seen = 0;
    int pulses_exp  = 0;
    int last_pulse_cyc = -1;

    // Reference model state, in terms of frames and run lengths.
    bit m_held;
    int m_code;
    int m_run_key;
    int m_run_len;
    int m_off_len;
    bit m_pulse;

    keypad_scanner #(.SCAN_DIV(S), .DEBOUNCE_CNT(D)) dut (
        .clk_2    (clk_2),
        .rst      (rst),
        .KEY_ROW  (KEY_ROW),
        .KEY_COL  (KEY_COL),
        .key_valid(key_valid),
        .key_code (key_code),
        .key_held (key_held)
    );

    always #5 clk_2 = ~clk_2;

    // Passive matrix: a pressed key shorts its column drive onto its row.
    always_comb begin
        KEY_ROW = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 3; c++)
                if (pressed[r*3 + c] && KEY_COL[c]) KEY_ROW[r] = 1'b1;
    end

    function automatic logic [11:0] key_mask(input int k);
        logic [11:0] one;
        one = 12'd1;
        return one << k;
    endfunction

    task automatic model_init();
        m_held = 0; m_code = 0; m_run_key = 0; m_run_len = 0; m_off_len = 0; m_pulse = 0;
    endtask

    task automatic model_step(input logic [11:0] mask);
        int  code;
        bit  single;
        single = ($countones(mask) == 1);
        code   = 0;
        for (int k = 0; k < 12; k++) if (mask[k]) code = k;
        if (!m_held) begin
            if (single) begin
                if (m_run_len > 0 && code == m_run_key) m_run_len++;
                else begin m_run_key = code; m_run_len = 1; end
            end else begin
                m_run_len = 0;
            end
            if (m_run_len == D) begin
                m_pulse = 1; m_held = 1; m_code = m_run_key; m_off_len = 0; m_run_len = 0;
                pulses_exp++;
            end
        end else begin
            if (single && code == m_code) m_off_len = 0;
            else m_off_len++;
            if (m_off_len == D) begin m_held = 0; m_run_len = 0; end
        end
    endtask

    // Applies one frame of key mask, aligned to frame boundaries, checking every cycle.
    task automatic run_frame(input logic [11:0] mask);
        logic [2:0] exp_col;
        logic [2:0] one;
        pressed = mask;
        one = 3'b001;
        for (int i = 1; i <= FRAME; i++) begin
            @(posedge clk_2); #1;
            cyc++;
            m_pulse = 0;
            if (i == FRAME) model_step(mask);
            exp_col = one << ((cyc % FRAME) / S);
            n_checks++;
            if (KEY_COL !== exp_col) begin
                n_fail++; $display("FAIL key_col cyc=%0d got=%b exp=%b", cyc, KEY_COL, exp_col);
            end
            n_checks++;
            if (key_valid !== m_pulse) begin
                n_fail++; $display("FAIL key_valid cyc=%0d got=%b exp=%b", cyc, key_valid, m_pulse);
            end
            n_checks++;
            if (key_held !== m_held) begin
                n_fail++; $display("FAIL key_held cyc=%0d got=%b exp=%b", cyc, key_held, m_held);
            end
            n_checks++;
            if (key_code !== 4'(m_code)) begin
                n_fail++; $display("FAIL key_code cyc=%0d got=%0d exp=%0d", cyc, key_code, m_code);
            end
            if (key_valid === 1'b1) begin
                if (last_pulse_cyc >= 0) begin
                    n_checks++;
                    if (cyc - last_pulse_cyc < 2 * D * FRAME) begin
                        n_fail++; $display("FAIL pulse_spacing cyc=%0d got=%0d exp>=%0d", cyc, cyc - last_pulse_cyc, 2 * D * FRAME);
                    end
                end
                pulses_seen++;
                last_pulse_cyc = cyc;
            end
        end
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        for (int k = 0; k < cycles; k++) begin
            @(posedge clk_2); #1;
            n_checks++;
            if (KEY_COL !== 3'b001 || key_valid !== 1'b0 || key_held !== 1'b0 || key_code !== 4'd0) begin
                n_fail++;
                $display("FAIL reset_state got col=%b v=%b h=%b code=%0d exp col=001 v=0 h=0 code=0",
                         KEY_COL, key_valid, key_held, key_code);
            end
        end
        rst = 1'b0;
        cyc = 0;
        last_pulse_cyc = -1;
        model_init();
    endtask

    task automatic test_reset();
        do_reset(3);
    endtask

    task automatic test_idle_scan();
        int p0;
        p0 = pulses_seen;
        for (int f = 0; f < 9; f++) run_frame('0);
        n_checks++;
        if (pulses_seen != p0 || key_code !== 4'd0) begin
            n_fail++; $display("FAIL idle_scan pulses=%0d code=%0d exp pulses=0 code=0", pulses_seen - p0, key_code);
        end
    endtask

    task automatic test_glitch();
        int p0;
        p0 = pulses_seen;
        run_frame('0);
        run_frame(key_mask(11));
        for (int f = 0; f < 4; f++) run_frame('0);
        n_checks++;
        if (pulses_seen != p0 || key_code !== 4'd0) begin
            n_fail++; $display("FAIL glitch pulses=%0d code=%0d exp pulses=0 code=0", pulses_seen - p0, key_code);
        end
    endtask

    task automatic test_multi();
        int p0;
        p0 = pulses_seen;
        for (int f = 0; f < 4; f++) run_frame(key_mask(0) | key_mask(3));
        n_checks++;
        if (pulses_seen != p0 || key_held !== 1'b0) begin
            n_fail++; $display("FAIL multi pulses=%0d held=%b exp pulses=0 held=0", pulses_seen - p0, key_held);
        end
        run_frame('0);
    endtask

    task automatic test_single_key();
        int p0;
        int start;
        p0 = pulses_seen;
        start = cyc;
        for (int f = 0; f < 5; f++) run_frame(key_mask(1));
        n_checks++;
        if (last_pulse_cyc != start + 3 * FRAME) begin
            n_fail++; $display("FAIL press_latency got_cyc=%0d exp_cyc=%0d", last_pulse_cyc, start + 3 * FRAME);
        end
        for (int f = 0; f < 4; f++) run_frame('0);
        n_checks++;
        if (pulses_seen != p0 + 1 || key_code !== 4'd1 || key_held !== 1'b0) begin
            n_fail++; $display("FAIL single_key pulses=%0d code=%0d held=%b exp pulses=1 code=1 held=0",
                               pulses_seen - p0, key_code, key_held);
        end
    endtask

    task automatic test_back_to_back();
        int p0;
        p0 = pulses_seen;
        for (int f = 0; f < 3; f++) run_frame(key_mask(4));
        run_frame('0);
        for (int f = 0; f < 2; f++) run_frame(key_mask(4));
        n_checks++;
        if (pulses_seen != p0 + 1 || key_held !== 1'b1) begin
            n_fail++; $display("FAIL rehold pulses=%0d held=%b exp pulses=1 held=1", pulses_seen - p0, key_held);
        end
        for (int f = 0; f < 3; f++) run_frame('0);
        for (int f = 0; f < 3; f++) run_frame(key_mask(7));
        // Rollover: key 8 while 7 is held must release first, then requalify.
        for (int f = 0; f < 6; f++) run_frame(key_mask(8));
        for (int f = 0; f < 3; f++) run_frame('0);
        n_checks++;
        if (pulses_seen != p0 + 3 || key_code !== 4'd8) begin
            n_fail++; $display("FAIL back_to_back pulses=%0d code=%0d exp pulses=3 code=8", pulses_seen - p0, key_code);
        end
    endtask

    task automatic test_reset_mid_confirm();
        int p0;
        p0 = pulses_seen;
        for (int f = 0; f < 2; f++) run_frame(key_mask(5));
        for (int k = 0; k < 5; k++) begin
            @(posedge clk_2); #1;
            n_checks++;
            if (key_valid !== 1'b0) begin
                n_fail++; $display("FAIL mid_frame_valid got=%b exp=0", key_valid);
            end
        end
        do_reset(2);
        for (int f = 0; f < 3; f++) run_frame(key_mask(5));
        n_checks++;
        if (pulses_seen != p0 + 1 || last_pulse_cyc != 3 * FRAME || key_code !== 4'd5) begin
            n_fail++; $display("FAIL reset_requalify pulses=%0d at=%0d code=%0d exp pulses=1 at=%0d code=5",
                               pulses_seen - p0, last_pulse_cyc, key_code, 3 * FRAME);
        end
        for (int f = 0; f < 3; f++) run_frame('0);
    endtask

    task automatic test_random();
        int last_key;
        int mode;
        int k1;
        int k2;
        last_key = 0;
        for (int f = 0; f < 90; f++) begin
            mode = int'($urandom_range(0, 9));
            if (mode <= 5) begin
                if ($urandom_range(0, 9) >= 7) last_key = int'($urandom_range(0, 11));
                run_frame(key_mask(last_key));
            end else if (mode <= 8) begin
                run_frame('0);
            end else begin
                k1 = int'($urandom_range(0, 11));
                k2 = (k1 + 1 + int'($urandom_range(0, 10))) % 12;
                run_frame(key_mask(k1) | key_mask(k2));
            end
        end
        for (int f = 0; f < 4; f++) run_frame('0);
        n_checks++;
        if (pulses_seen != pulses_exp) begin
            n_fail++; $display("FAIL total_pulses got=%0d exp=%0d", pulses_seen, pulses_exp);
        end
    endtask

    initial begin
        model_init();
        test_reset();
        test_idle_scan();
        test_glitch();
        test_multi();
        test_single_key();
        test_back_to_back();
        test_reset_mid_confirm();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
